multicycle_shifter: RTL and testbench
=====================================

MULTICYCLE_SHIFTER -- requirements
Module: multicycle_shifter

Interface
REQ-001 The module SHALL have these ports, one per line: name, direction, width, meaning.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 start  input  1  request; accepted only while idle.
REQ-005 shift_op  input  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROTR (rotate right).
REQ-006 shift_amount  input  5  shift distance, 0..31.
REQ-007 data  input  32  operand.
REQ-008 busy  output  1  high while a request is in progress.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 result  output  32  final shifted value; holds until the next completion.

Function
REQ-011 The block SHALL implement the states IDLE, SHIFT and DONE.
REQ-012 In IDLE with start=1 at an edge, the block SHALL capture data, shift_op and shift_amount into internal registers and set busy=1.
REQ-013 If the captured shift_amount=0, the next state SHALL be DONE; otherwise it SHALL be SHIFT.
REQ-014 Each SHIFT cycle SHALL apply step = min(remaining, STEP) bits of the captured op to the work register and reduce remaining by step; STEP is defined in Configuration.
REQ-015 The block SHALL go from SHIFT to DONE on the edge where remaining reaches 0.
REQ-016 Arithmetic rules: SLL and SRL zero-fill; SRA fills with the original bit 31; ROTR feeds the bits shifted out of bit 0 back in at bit 31; all operations stay 32-bit.
REQ-017 On entry to DONE, result SHALL be loaded with the final work value, done SHALL be 1 for exactly one cycle, and busy SHALL remain 1 during that cycle.
REQ-018 From DONE the next state SHALL be IDLE, with busy=0 and done=0.
REQ-019 Latency: done SHALL assert ceil(N/STEP)+1 cycles after the accepting edge, where N is the captured shift_amount; N=0 gives 1 cycle.
REQ-020 start SHALL be ignored while busy=1, including in the DONE cycle; a held start is accepted again in the first IDLE cycle.
REQ-021 Changes on data, shift_op or shift_amount after acceptance SHALL NOT affect the in-flight operation.
REQ-022 result SHALL change only on the edge that enters DONE; intermediate work values SHALL never appear on result.
REQ-023 Back-to-back operation: a start held high SHALL give one accepted request every ceil(N/STEP)+2 cycles.

Reset
REQ-024 While rst_n=0 at an edge, the block SHALL force state=IDLE, busy=0, done=0, result=0x00000000 and clear all internal registers.
REQ-025 Reset asserted mid-operation SHALL abort the operation with no done pulse, and the pre-reset result SHALL be lost (result=0).
REQ-026 start sampled at an edge where rst_n=0 SHALL be discarded.

Configuration
REQ-027 Macro MCSHIFT_FAST_STEP_EN: when defined, STEP=4, giving a maximum latency of 9 cycles for N=31.
REQ-028 When MCSHIFT_FAST_STEP_EN is undefined, STEP=1, giving a maximum latency of 32 cycles for N=31.
REQ-029 The final result SHALL be identical with and without the macro; only latency differs.

Verification
REQ-030 SLL with data=0x00000001 and amount=31 -> result=0x80000000; done 32 cycles after acceptance (9 with MCSHIFT_FAST_STEP_EN).
REQ-031 SRA with data=0x80000000 and amount=4 -> result=0xF8000000; SRL with the same operands -> 0x08000000; with the macro, done 2 cycles after acceptance in both cases.
REQ-032 ROTR with data=0x00000001 and amount=1 -> result=0x80000000; ROTR with data=0x12345678 and amount=8 -> 0x78123456.
REQ-033 Any op with amount=0 and data=0xDEADBEEF -> result=0xDEADBEEF; done exactly 1 cycle after acceptance.
REQ-034 Assert start again with new operands while busy -> ignored; result reflects only the first request; exactly one done pulse.
REQ-035 Drive rst_n=0 for one cycle at the 3rd SHIFT cycle of an SLL with amount=20 -> busy=0, result=0, no done pulse; the next request completes normally.

Source files
------------

// File: rtl/multicycle_shifter.sv
// Iterative 32-bit shifter (SLL/SRL/SRA/ROTR) that moves STEP bits per cycle; `MCSHIFT_FAST_STEP_EN selects STEP=4, otherwise STEP=1.
// Latency: done asserts ceil(N/STEP)+1 cycles after the accepting edge (1 cycle for N=0).
// Backpressure: start is accepted only in IDLE; busy stays high through the DONE cycle.
module multicycle_shifter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  shift_op,
    input  logic [4:0]  shift_amount,
    input  logic [31:0] data,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

`ifdef MCSHIFT_FAST_STEP_EN
    localparam logic [4:0] STEP = 5'd4;
`else
    localparam logic [4:0] STEP = 5'd1;
`endif

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b10;

    logic [1:0]  state;
    logic [1:0]  op_q;
    logic [4:0]  remaining;
    logic [31:0] work;

    logic [4:0]  step;
    logic [4:0]  remaining_next;
    logic [31:0] work_next;
    logic [5:0]  rot_back;

    // SRA stays correct step by step because bit 31 of work always equals the original sign bit.
    always_comb begin
        step           = (remaining < STEP) ? remaining : STEP;
        remaining_next = remaining - step;
        rot_back       = 6'd32 - {1'b0, step};
        work_next      = work;
        case (op_q)
            OP_SLL:  work_next = work << step;
            OP_SRL:  work_next = work >> step;
            OP_SRA:  work_next = $unsigned($signed(work) >>> step);
            default: work_next = (work >> step) | (work << rot_back);
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            op_q      <= 2'b00;
            remaining <= 5'd0;
            work      <= 32'd0;
            result    <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_q      <= shift_op;
                        remaining <= shift_amount;
                        work      <= data;
                        if (shift_amount == 5'd0) begin
                            result <= data;
                            state  <= ST_DONE;
                        end else begin
                            state  <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    work      <= work_next;
                    remaining <= remaining_next;
                    // The final step lands directly in result so partial values never show.
                    if (remaining_next == 5'd0) begin
                        result <= work_next;
                        state  <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_multicycle_shifter.sv
// Scoreboard bench for multicycle_shifter: expected result/latency queued at issue, popped at done.
module tb_multicycle_shifter;

`ifdef MCSHIFT_FAST_STEP_EN
    localparam int STEP = 4;
`else
    localparam int STEP = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  shift_op = 2'b00;
    logic [4:0]  shift_amount = 5'd0;
    logic [31:0] data = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];
    int          lat_q[$];

    multicycle_shifter dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .shift_op(shift_op),
        .shift_amount(shift_amount),
        .data(data),
        .busy(busy),
        .done(done),
        .result(result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] op, input logic [4:0] n, input logic [31:0] d);
        logic [63:0] dd;
        dd = {d, d};
        case (op)
            2'b00:   return d << n;
            2'b01:   return d >> n;
            2'b10:   return $unsigned($signed(d) >>> n);
            default: return dd[n +: 32];
        endcase
    endfunction

    function automatic int exp_lat(input logic [4:0] n);
        return (int'(n) + STEP - 1) / STEP + 1;
    endfunction

    task automatic scramble();
        data         = $urandom;
        shift_op     = 2'($urandom);
        shift_amount = 5'($urandom);
    endtask

    // Issue one request from IDLE; with hold=1 start stays high (new operands) until done.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [4:0] n,
                          input logic [31:0] d, input bit hold);
        logic [31:0] prev;
        logic [31:0] e;
        int          lat;
        int          el;
        bit          stable;
        @(negedge clk);
        prev   = result;
        stable = 1'b1;
        start  = 1'b1;
        shift_op = op;
        shift_amount = n;
        data   = d;
        exp_q.push_back(model(op, n, d));
        lat_q.push_back(exp_lat(n));
        @(negedge clk);
        lat = 1;
        check({tag, "_busy_after_accept"}, 32'(busy), 32'd1);
        start = hold;
        scramble();
        while (!done && lat < 200) begin
            if (result !== prev) stable = 1'b0;
            @(negedge clk);
            lat++;
            if (hold) scramble();
        end
        start = 1'b0;
        if (!done) begin
            check({tag, "_done_timeout"}, 32'd0, 32'd1);
            exp_q.delete();
            lat_q.delete();
            return;
        end
        e  = exp_q.pop_front();
        el = lat_q.pop_front();
        check({tag, "_result"}, result, e);
        check({tag, "_latency"}, 32'(lat), 32'(el));
        check({tag, "_busy_in_done"}, 32'(busy), 32'd1);
        check({tag, "_result_stable"}, 32'(stable), 32'd1);
        @(negedge clk);
        check({tag, "_done_pulse_end"}, 32'(done), 32'd0);
        check({tag, "_idle_after_done"}, 32'(busy), 32'd0);
        check({tag, "_result_hold"}, result, e);
    endtask

    task automatic back_to_back();
        int cyc;
        logic [31:0] e;
        @(negedge clk);
        start = 1'b1;
        shift_op = 2'b01;
        shift_amount = 5'd3;
        data = 32'hF0F0_F0F0;
        exp_q.push_back(model(2'b01, 5'd3, 32'hF0F0_F0F0));
        exp_q.push_back(model(2'b01, 5'd3, 32'hF0F0_F0F0));
        cyc = 0;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("b2b_first_done_seen", 32'(done), 32'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("b2b_first_result", result, e);
        end
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!done && cyc < 200);
        start = 1'b0;
        check("b2b_period", 32'(cyc), 32'(exp_lat(5'd3) + 1));
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("b2b_second_result", result, e);
        end
        @(negedge clk);
        check("b2b_idle", 32'(busy), 32'd0);
    endtask

    task automatic reset_mid_op();
        int pulses;
        logic [31:0] prev;
        @(negedge clk);
        prev = result;
        check("rst_prior_result_nonzero", 32'(prev != 32'd0), 32'd1);
        start = 1'b1;
        shift_op = 2'b00;
        shift_amount = 5'd20;
        data = 32'h0000_0001;
        @(negedge clk);
        start = 1'b0;
        pulses = 0;
        repeat (2) begin
            @(negedge clk);
            if (done) pulses++;
        end
        // Third SHIFT cycle: reset together with a start that must be discarded.
        rst_n = 1'b0;
        start = 1'b1;
        data  = 32'h1234_5678;
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", result, 32'd0);
        repeat (25) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("rst_no_done_pulse", 32'(pulses), 32'd0);
        check("rst_still_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b1;
        data  = 32'hCAFE_F00D;
        shift_amount = 5'd5;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_result", result, 32'd0);
        rst_n = 1'b1;
        start = 1'b0;

        run_op("sll31",       2'b00, 5'd31, 32'h0000_0001, 1'b0);
        run_op("sra4",        2'b10, 5'd4,  32'h8000_0000, 1'b0);
        run_op("srl4",        2'b01, 5'd4,  32'h8000_0000, 1'b0);
        run_op("rotr1",       2'b11, 5'd1,  32'h0000_0001, 1'b0);
        run_op("rotr8",       2'b11, 5'd8,  32'h1234_5678, 1'b0);
        for (int i = 0; i < 4; i++)
            run_op("zero_amt", 2'(i), 5'd0, 32'hDEAD_BEEF, 1'b0);
        run_op("sra_pos",     2'b10, 5'd7,  32'h7FFF_FFFF, 1'b0);
        run_op("rotr31",      2'b11, 5'd31, 32'h8000_0001, 1'b0);
        run_op("busy_ignore", 2'b00, 5'd20, 32'h0000_0003, 1'b1);
        run_op("busy_zero",   2'b11, 5'd0,  32'h0BAD_CAFE, 1'b1);
        back_to_back();
        reset_mid_op();
        run_op("post_reset",  2'b00, 5'd20, 32'h0000_0001, 1'b0);
        for (int i = 0; i < 20; i++)
            run_op("random", 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), $urandom, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
